// File: rtl/leapfrog_step.sv
// leapfrog_step: one kick-drift (leapfrog) integration step over every active body.
// Latency: 3 cycles per body plus a DONE cycle; start at edge k gives done in cycle k+3n+1.
// Backpressure: none; RAM reads/writes are fixed latency and start is ignored while busy.

module leapfrog_step #(
  parameter int BODIES     = 512,
  parameter int DATA_WIDTH = 32,
  parameter int DT_SHIFT   = 4,
  localparam int AW        = (BODIES > 1) ? $clog2(BODIES) : 1,
  localparam int NW        = $clog2(BODIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NW-1:0]         n_bodies,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_pos_x,
  input  logic [DATA_WIDTH-1:0] rd_pos_y,
  input  logic [DATA_WIDTH-1:0] rd_vel_x,
  input  logic [DATA_WIDTH-1:0] rd_vel_y,
  input  logic [DATA_WIDTH-1:0] rd_acc_x,
  input  logic [DATA_WIDTH-1:0] rd_acc_y,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_pos_x,
  output logic [DATA_WIDTH-1:0] wr_pos_y,
  output logic [DATA_WIDTH-1:0] wr_vel_x,
  output logic [DATA_WIDTH-1:0] wr_vel_y
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // One body's state as read from the RAMs, held for the WRITE cycle.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pos_x;
    logic [DATA_WIDTH-1:0] pos_y;
    logic [DATA_WIDTH-1:0] vel_x;
    logic [DATA_WIDTH-1:0] vel_y;
    logic [DATA_WIDTH-1:0] acc_x;
    logic [DATA_WIDTH-1:0] acc_y;
  } body_t;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [NW-1:0] n_q, n_d;
  body_t         body_q, body_d;

  logic [NW-1:0] n_cap;
  logic          last_body;

  logic [DATA_WIDTH-1:0] vel_x_new, vel_y_new;
  logic [DATA_WIDTH-1:0] pos_x_new, pos_y_new;

  // Two's-complement add evaluated one bit wider, then clamped to the signed range.
  function automatic logic [DATA_WIDTH-1:0] sat_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    case (sum[DATA_WIDTH:DATA_WIDTH-1])
      2'b01:   sat_add = SAT_MAX;
      2'b10:   sat_add = SAT_MIN;
      default: sat_add = sum[DATA_WIDTH-1:0];
    endcase
  endfunction

  // Multiply by dt: arithmetic right shift, which rounds toward minus infinity.
  function automatic logic [DATA_WIDTH-1:0] asr_dt(input logic [DATA_WIDTH-1:0] x);
    asr_dt = $unsigned($signed(x) >>> DT_SHIFT);
  endfunction

  // Body count requested beyond the RAM depth is clamped to the RAM depth.
  assign n_cap     = (n_bodies > NW'(BODIES)) ? NW'(BODIES) : n_bodies;
  assign last_body = (NW'(idx_q) == (n_q - NW'(1)));

  // State register and all datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      body_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      body_q  <= body_d;
    end
  end

  // Next-state selection; start only matters in IDLE, so it is ignored while busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (n_cap == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_WRITE;
      S_WRITE: state_d = last_body ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Body count capture, index stepping and capture of the RAM read data.
  always_comb begin
    idx_d  = idx_q;
    n_d    = n_q;
    body_d = body_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = n_cap;
          idx_d = '0;
        end
      end
      S_LATCH: begin
        body_d.pos_x = rd_pos_x;
        body_d.pos_y = rd_pos_y;
        body_d.vel_x = rd_vel_x;
        body_d.vel_y = rd_vel_y;
        body_d.acc_x = rd_acc_x;
        body_d.acc_y = rd_acc_y;
      end
      S_WRITE: begin
        if (!last_body) begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Kick (velocity from acceleration) then drift (position from the updated velocity).
  always_comb begin
    vel_x_new = sat_add(body_q.vel_x, asr_dt(body_q.acc_x));
    vel_y_new = sat_add(body_q.vel_y, asr_dt(body_q.acc_y));
    pos_x_new = sat_add(body_q.pos_x, asr_dt(vel_x_new));
    pos_y_new = sat_add(body_q.pos_y, asr_dt(vel_y_new));
  end

  // Status and write strobe decoded from the current state.
  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    wr_en = (state_q == S_WRITE);
  end

  assign rd_addr  = idx_q;
  assign wr_addr  = idx_q;
  assign wr_pos_x = pos_x_new;
  assign wr_pos_y = pos_y_new;
  assign wr_vel_x = vel_x_new;
  assign wr_vel_y = vel_y_new;

endmodule

// File: tb/tb_leapfrog_step.sv
// tb_leapfrog_step: directed and randomized steps against a plain-arithmetic reference model.
// RAM model returns data one cycle after rd_addr; writes are recorded with their cycle offset.
// Outputs are sampled on the falling edge; inputs change on the falling edge.

module tb_leapfrog_step;

  localparam int BODIES = 512;
  localparam int DW     = 32;
  localparam int DT     = 4;
  localparam int AW     = 9;
  localparam int NW     = 10;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start;
  logic [NW-1:0] n_bodies;
  logic          busy, done, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_pos_x, rd_pos_y, rd_vel_x, rd_vel_y, rd_acc_x, rd_acc_y;
  logic [DW-1:0] wr_pos_x, wr_pos_y, wr_vel_x, wr_vel_y;

  leapfrog_step #(.BODIES(BODIES), .DATA_WIDTH(DW), .DT_SHIFT(DT)) dut (
    .clk(clk), .rst(rst), .start(start), .n_bodies(n_bodies),
    .busy(busy), .done(done), .rd_addr(rd_addr),
    .rd_pos_x(rd_pos_x), .rd_pos_y(rd_pos_y), .rd_vel_x(rd_vel_x),
    .rd_vel_y(rd_vel_y), .rd_acc_x(rd_acc_x), .rd_acc_y(rd_acc_y),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_pos_x(wr_pos_x), .wr_pos_y(wr_pos_y), .wr_vel_x(wr_vel_x), .wr_vel_y(wr_vel_y)
  );

  logic [DW-1:0] m_px[BODIES];
  logic [DW-1:0] m_py[BODIES];
  logic [DW-1:0] m_vx[BODIES];
  logic [DW-1:0] m_vy[BODIES];
  logic [DW-1:0] m_ax[BODIES];
  logic [DW-1:0] m_ay[BODIES];

  // Synchronous-read RAMs: data appears the cycle after the address.
  always @(posedge clk) begin
    rd_pos_x <= m_px[rd_addr];
    rd_pos_y <= m_py[rd_addr];
    rd_vel_x <= m_vx[rd_addr];
    rd_vel_y <= m_vy[rd_addr];
    rd_acc_x <= m_ax[rd_addr];
    rd_acc_y <= m_ay[rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            addr;
    logic [DW-1:0] px, py, vx, vy;
    int            r;
  } wrec_t;

  wrec_t wq[$];
  int    dq[$];
  int    errors = 0;
  int    checks = 0;
  int    k = 0;
  int    r = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log any write or done seen in that cycle.
  task automatic tick();
    @(negedge clk);
    r = cyc - k + 1;
    if (wr_en === 1'b1) wq.push_back('{int'(wr_addr), wr_pos_x, wr_pos_y, wr_vel_x, wr_vel_y, r});
    if (done === 1'b1) dq.push_back(r);
  endtask

  // Reference arithmetic: real floor division by 2^DT and clamping to 32-bit signed.
  function automatic longint sx(input logic [DW-1:0] v);
    sx = longint'(signed'(v));
  endfunction

  function automatic longint floor_dt(input longint x);
    longint d, q;
    d = longint'(1) << DT;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [DW-1:0] clamp(input longint x);
    if (x > SMAX) return 32'h7FFF_FFFF;
    if (x < SMIN) return 32'h8000_0000;
    return x[31:0];
  endfunction

  function automatic logic [DW-1:0] rnd();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 255));
      3:       return -32'($urandom_range(1, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < BODIES; i++) begin
      m_px[i] = '0; m_py[i] = '0; m_vx[i] = '0;
      m_vy[i] = '0; m_ax[i] = '0; m_ay[i] = '0;
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      m_px[i] = rnd(); m_py[i] = rnd() ^ (32'(i) << 16);
      m_vx[i] = rnd(); m_vy[i] = rnd();
      m_ax[i] = rnd(); m_ay[i] = rnd();
    end
  endtask

  // Issue one start and watch for 3n+12 cycles; optionally pulse start while busy and on done.
  task automatic do_step(input int n_req, input bit spurious);
    int n_exp, dr;
    n_exp = (n_req > BODIES) ? BODIES : n_req;
    dr    = 3 * n_exp + 1;
    wq.delete();
    dq.delete();
    n_bodies = NW'(n_req);
    start    = 1'b1;
    k        = cyc + 1;
    for (int t = 0; t < 3 * n_exp + 12; t++) begin
      tick();
      start = spurious && ((r == 2 && n_exp > 0) || r == dr);
    end
    start = 1'b0;
  endtask

  task automatic check_step(input int n_exp, input string tag);
    int nw;
    chk({tag, "_done_count"}, dq.size(), 1);
    if (dq.size() > 0) chk({tag, "_done_cycle"}, dq[0], 3 * n_exp + 1);
    chk({tag, "_write_count"}, wq.size(), n_exp);
    nw = (wq.size() < n_exp) ? wq.size() : n_exp;
    for (int i = 0; i < nw; i++) begin
      logic [DW-1:0] evx, evy, epx, epy;
      evx = clamp(sx(m_vx[i]) + floor_dt(sx(m_ax[i])));
      evy = clamp(sx(m_vy[i]) + floor_dt(sx(m_ay[i])));
      epx = clamp(sx(m_px[i]) + floor_dt(sx(evx)));
      epy = clamp(sx(m_py[i]) + floor_dt(sx(evy)));
      chk($sformatf("%s_b%0d_addr", tag, i), wq[i].addr, i);
      chk($sformatf("%s_b%0d_cycle", tag, i), wq[i].r, 3 + 3 * i);
      chk($sformatf("%s_b%0d_vx", tag, i), wq[i].vx, evx);
      chk($sformatf("%s_b%0d_vy", tag, i), wq[i].vy, evy);
      chk($sformatf("%s_b%0d_px", tag, i), wq[i].px, epx);
      chk($sformatf("%s_b%0d_py", tag, i), wq[i].py, epy);
    end
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_bodies = '0;
    clear_mem();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_pos_x", wr_pos_x, 0);
    chk("rst_wr_pos_y", wr_pos_y, 0);
    chk("rst_wr_vel_x", wr_vel_x, 0);
    chk("rst_wr_vel_y", wr_vel_y, 0);

    // Unit acceleration on one body
    clear_mem();
    m_ax[0] = 32'h0001_0000;
    do_step(1, 1'b0);
    check_step(1, "unit");
    if (wq.size() > 0) begin
      chk("unit_vx_const", wq[0].vx, 32'h0000_1000);
      chk("unit_px_const", wq[0].px, 32'h0000_0100);
    end

    // Saturation at both ends
    clear_mem();
    m_vx[0] = 32'h7FFF_FFFF; m_ax[0] = 32'h7FFF_0000;
    m_vx[1] = 32'h8000_0000; m_ax[1] = 32'h8000_0000;
    do_step(2, 1'b0);
    check_step(2, "sat");
    if (wq.size() > 1) begin
      chk("sat_pos_vx_const", wq[0].vx, 32'h7FFF_FFFF);
      chk("sat_neg_vx_const", wq[1].vx, 32'h8000_0000);
    end

    // Floor rounding of a negative shift
    clear_mem();
    m_px[0] = 32'h0001_2345; m_ax[0] = 32'hFFFF_FFFF;
    do_step(1, 1'b0);
    check_step(1, "floor");
    if (wq.size() > 0) begin
      chk("floor_vx_const", wq[0].vx, 32'hFFFF_FFFF);
      chk("floor_px_const", wq[0].px, 32'h0001_2344);
    end

    // Randomized steps, one with spurious starts
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 40);
      clear_mem();
      fill_random(n);
      do_step(n, it == 2);
      check_step(n, $sformatf("rand%0d", it));
    end

    // Zero bodies, with a start pulse in the done cycle
    do_step(0, 1'b1);
    check_step(0, "zero");

    // Full RAM, distinct data
    clear_mem();
    fill_random(BODIES);
    do_step(BODIES, 1'b0);
    check_step(BODIES, "full");

    // Request above the RAM depth is clamped
    do_step(700, 1'b1);
    check_step(BODIES, "clamp");

    // Abort after body 2 with rst and start together, then a clean restart
    clear_mem();
    fill_random(8);
    wq.delete();
    dq.delete();
    n_bodies = NW'(8);
    start = 1'b1;
    k = cyc + 1;
    for (int t = 0; t < 40 && wq.size() < 3; t++) begin
      tick();
      start = 1'b0;
    end
    chk("abort_pre_writes", wq.size(), 3);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("abort_busy_now", busy, 0);
    repeat (30) tick();
    chk("abort_total_writes", wq.size(), 3);
    chk("abort_no_done", dq.size(), 0);
    chk("abort_busy_later", busy, 0);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_wr_vel_x", wr_vel_x, 0);
    chk("abort_wr_pos_y", wr_pos_y, 0);
    do_step(8, 1'b0);
    check_step(8, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/leapfrog_step.md
LEAPFROG_STEP -- requirements
Module: leapfrog_step

Interface
REQ-001 SHALL have parameter BODIES, default 512, maximum body count.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, signed Q16.16 fixed-point component width.
REQ-003 SHALL have parameter DT_SHIFT, default 4, timestep dt = 2^-DT_SHIFT.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to integrate one timestep.
REQ-007 SHALL have port n_bodies, input, clog2(BODIES+1), active body count sampled at start.
REQ-008 SHALL have port busy, output, 1, high while a step is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when the step completes.
REQ-010 SHALL have port rd_addr, output, clog2(BODIES), body index into position, velocity and acceleration RAMs.
REQ-011 SHALL have ports rd_pos_x, rd_pos_y, rd_vel_x, rd_vel_y, rd_acc_x, rd_acc_y, input, DATA_WIDTH each, RAM data valid one cycle after rd_addr.
REQ-012 SHALL have port wr_en, output, 1, write strobe for position and velocity RAMs.
REQ-013 SHALL have port wr_addr, output, clog2(BODIES), body index written.
REQ-014 SHALL have ports wr_pos_x, wr_pos_y, wr_vel_x, wr_vel_y, output, DATA_WIDTH each, updated state.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LATCH, WRITE, DONE.
REQ-016 In IDLE with start=1 it SHALL capture n = min(n_bodies, BODIES), clear index, and go to FETCH; if n=0 it SHALL go directly to DONE.
REQ-017 FETCH SHALL drive rd_addr=index for one cycle, then go to LATCH.
REQ-018 LATCH SHALL register all six rd_* inputs, then go to WRITE.
REQ-019 WRITE SHALL assert wr_en for exactly one cycle with wr_addr=index and the results of REQ-020/021.
REQ-020 Kick: v' = sat(v + (a >>> DT_SHIFT)) per axis; >>> is arithmetic shift (floor toward -inf).
REQ-021 Drift: p' = sat(p + (v' >>> DT_SHIFT)) per axis, using the updated v'.
REQ-022 sat SHALL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; sums SHALL be computed at DATA_WIDTH+1 bits before clamping.
REQ-023 After WRITE: if index = n-1, go to DONE; otherwise increment index and go to FETCH.
REQ-024 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-025 Timing: start sampled at edge k; body i written in cycle k+3+3i; done high in cycle k+3n+1; for n=0, done high in cycle k+1.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 start SHALL be ignored while busy; start in the same cycle as done SHALL be ignored.
REQ-028 Each body SHALL be written exactly once per step, in ascending index order.

Reset
REQ-029 rst SHALL force IDLE, busy=0, done=0, wr_en=0, rd_addr=0, wr_addr=0, and zero all wr_* data and internal registers.
REQ-030 rst asserted mid-step SHALL abort with no further wr_en; a later start SHALL restart from index 0.
REQ-031 With rst and start high together, rst SHALL win.

Verification
REQ-032 DT_SHIFT=4, n=1, pos=0, vel=0, acc_x=0x00010000 -> wr_vel_x=0x00001000, wr_pos_x=0x00000100, done at k+4.
REQ-033 vel_x=0x7FFFFFFF, acc_x=0x7FFF0000 -> wr_vel_x=0x7FFFFFFF (saturated); vel_x=0x80000000, acc_x=0x80000000 -> wr_vel_x=0x80000000.
REQ-034 vel=0, acc_x=0xFFFFFFFF -> wr_vel_x=0xFFFFFFFF, wr_pos_x=pos_x-1 (floor shift).
REQ-035 n_bodies=512 with distinct per-body data -> 512 wr_en pulses, addresses 0..511 in order, done at k+1537; n_bodies=0 -> no wr_en, done at k+1.
REQ-036 rst pulsed after body 2 is written with n=8 -> no further writes, busy=0; a new start writes bodies 0..7.
REQ-037 start pulsed during busy and in the done cycle -> ignored; write count and done timing unchanged.
